// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the CNN pooling stages.
package cnn_pool_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned WIDE_WIDTH = 32;

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;
  typedef logic signed [WIDE_WIDTH-1:0] wide_t;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Callers sign-extend narrower operands into wide_t before comparing.
  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Single-port register array holding one row of horizontal partial results.
module pool_line_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 14,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // No reset: every entry is written on an even row before it is read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 pooling of one raster-order channel.
// Define POOL_AVG_EN to add the pool_mode input and the average path.
module max_pool_2x2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef POOL_AVG_EN
  input  logic                  pool_mode,
`endif
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);
  import cnn_pool_pkg::*;

  localparam int unsigned CW    = $clog2(IMG_WIDTH);
  localparam int unsigned RW    = $clog2(IMG_HEIGHT);
  localparam int unsigned DEPTH = IMG_WIDTH / 2;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned SW    = DATA_WIDTH + 2;
`else
  localparam int unsigned SW    = DATA_WIDTH;
`endif

  if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
    $error("max_pool_2x2: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
    $error("max_pool_2x2: IMG_HEIGHT must be even and >= 2");
  end

  function automatic logic signed [SW-1:0] pick_max(input logic signed [SW-1:0] a,
                                                     input logic signed [SW-1:0] b);
    wide_t m;
    m = smax(wide_t'(a), wide_t'(b));
    return m[SW-1:0];
  endfunction

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic signed [SW-1:0]  pair_q, pair_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;

  logic                  col_last, row_last, lb_we, avg_sel;
  logic [AW-1:0]         lb_addr;
  logic signed [SW-1:0]  in_ext, lb_rdata, hcomb, vcomb, vres;

  assign col_last = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
  assign lb_addr  = AW'(col_q >> 1);
  assign in_ext   = SW'($signed(in_data));

`ifdef POOL_AVG_EN
  logic mode_q, mode_d;

  // Mode is latched on the first pixel of a frame and used by every later window.
  always_comb begin
    mode_d = mode_q;
    if (in_valid && !clr && col_q == '0 && row_q == '0) begin
      mode_d = pool_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign avg_sel = (mode_q == POOL_AVG);
`else
  assign avg_sel = 1'b0;
`endif

  assign hcomb = avg_sel ? (pair_q + in_ext) : pick_max(pair_q, in_ext);
  assign vcomb = avg_sel ? (lb_rdata + hcomb) : pick_max(lb_rdata, hcomb);
  assign vres  = avg_sel ? (vcomb >>> 2) : vcomb;

  pool_line_buffer #(
    .WIDTH (SW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk_i   (clk),
    .we_i    (lb_we),
    .addr_i  (lb_addr),
    .wdata_i (hcomb),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    if (clr) begin
      col_d  = '0;
      row_d  = '0;
      pair_d = '0;
    end else if (in_valid) begin
      if (!col_q[0]) begin
        pair_d = in_ext;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_data_d   = vres[DATA_WIDTH-1:0];
        frame_done_d = col_last && row_last;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2 on a 4x4 frame with a behavioural window model.
module tb_max_pool_2x2;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, pool_mode;
  logic [7:0] in_data;
  logic       out_valid, frame_done;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  max_pool_2x2 #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
`ifdef POOL_AVG_EN
    .pool_mode  (pool_mode),
`endif
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  int   total = 0;
  int   bad = 0;
  int   img [H][W];
  int   mr, mc, m_out, n_out, n_acc;
  logic m_mode, exp_v, exp_fd;
  int   f [16];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Floor division by 4, correct for negative sums.
  function automatic int floor4(input int s);
    return (s - (((s % 4) + 4) % 4)) / 4;
  endfunction

  task automatic model_reset();
    mr = 0;
    mc = 0;
    m_out = 0;
  endtask

  task automatic step(input logic v, input int d, input logic c);
    int a, b, e, g, s, mx;
    in_valid = v;
    in_data  = d[7:0];
    clr      = c;
    @(posedge clk);
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    if (c) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      n_acc++;
      if (mr == 0 && mc == 0) m_mode = pool_mode;
      img[mr][mc] = int'($signed(in_data));
      if ((mr % 2) == 1 && (mc % 2) == 1) begin
        a = img[mr-1][mc-1];
        b = img[mr-1][mc];
        e = img[mr][mc-1];
        g = img[mr][mc];
        s = a + b + e + g;
        mx = a;
        if (b > mx) mx = b;
        if (e > mx) mx = e;
        if (g > mx) mx = g;
        m_out  = m_mode ? floor4(s) : mx;
        exp_v  = 1'b1;
        exp_fd = (mr == H - 1) && (mc == W - 1);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
    #1;
    if (out_valid === 1'b1) n_out++;
    check("out_valid", {7'b0, out_valid}, {7'b0, exp_v});
    check("frame_done", {7'b0, frame_done}, {7'b0, exp_fd});
    check("out_data", out_data, m_out[7:0]);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; pool_mode = 1'b0;
    m_mode = 1'b0; n_out = 0; n_acc = 0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_out_valid", {7'b0, out_valid}, 8'd0);
    check("rst_out_data", out_data, 8'd0);
    check("rst_frame_done", {7'b0, frame_done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp frame, no gaps.
    for (int i = 0; i < 16; i++) step(1'b1, i, 1'b0);
    check("ramp_last", out_data, 8'd15);

    // Signed window in the top-left corner.
    for (int i = 0; i < 16; i++) f[i] = i;
    f[0] = -3; f[1] = -8; f[4] = -1; f[5] = -128;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, f[i], 1'b0);
      if (i == 5) check("signed_win", out_data, 8'hFF);
    end

    // Ramp with a gap after every pixel.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i, 1'b0);
      step(1'b0, int'($urandom_range(0, 255)), 1'b0);
    end

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 6; i++) step(1'b1, 100 + i, 1'b0);
    rst = 1'b1;
    #2;
    check("mid_rst_valid", {7'b0, out_valid}, 8'd0);
    check("mid_rst_data", out_data, 8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    n_out = 0;
    for (int i = 0; i < 16; i++) step(1'b1, i, 1'b0);
    check("post_rst_count", n_out[7:0], 8'd4);
    check("post_rst_last", out_data, 8'd15);

    // clr coincident with pixel 9, then a constant frame.
    for (int i = 0; i < 9; i++) step(1'b1, i, 1'b0);
    step(1'b1, 9, 1'b1);
    n_out = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 16, 1'b0);
    check("clr_count", n_out[7:0], 8'd4);
    check("clr_value", out_data, 8'h10);

    // Random data with random gaps, three whole frames.
    n_acc = 0;
    while (n_acc < 48) begin
      if ($urandom_range(0, 2) == 0) step(1'b0, int'($urandom_range(0, 255)), 1'b0);
      else step(1'b1, int'($urandom_range(0, 255)), 1'b0);
    end

`ifdef POOL_AVG_EN
    pool_mode = 1'b1;
    for (int i = 0; i < 16; i++) f[i] = i;
    f[0] = 1; f[1] = 2; f[4] = 5; f[5] = 6;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, f[i], 1'b0);
      if (i == 5) check("avg_pos", out_data, 8'd3);
    end
    for (int i = 0; i < 16; i++) f[i] = -(i + 1);
    f[0] = -1; f[1] = -1; f[4] = -1; f[5] = -2;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) pool_mode = 1'b0;
      step(1'b1, f[i], 1'b0);
      if (i == 5) check("avg_neg", out_data, 8'hFE);
    end
    pool_mode = 1'b1;
    n_acc = 0;
    while (n_acc < 32) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 0, 1'b0);
      else step(1'b1, int'($urandom_range(0, 255)), 1'b0);
    end
    pool_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage for one feature-map channel.
- Consumes raster-order activation pixels and produces one pooled pixel per 2x2 window.
- Sits directly upstream of the activation/pooling output mux and drives its pooling input.
- Output width equals input width, so it connects to the mux pooling input without adaptation.

Parameters:
- DATA_WIDTH, 8, pixel width in bits; two's-complement signed.
- IMG_WIDTH, 28, input columns per row; must be even and at least 2.
- IMG_HEIGHT, 28, input rows per frame; must be even and at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous frame restart; clears counters and pending state.
- in_valid  input  1  in_data is accepted on this edge.
- in_data  input  DATA_WIDTH  input pixel, raster order.
- out_valid  output  1  one-cycle strobe; out_data holds a new pooled pixel.
- out_data  output  DATA_WIDTH  pooled pixel; holds its value between strobes.
- frame_done  output  1  one-cycle strobe coincident with the last pooled pixel of a frame.

Behaviour:
- Reset (rst=1, asynchronous): out_valid=0, out_data=0, frame_done=0, col=0, row=0, pair register=0. Line-buffer contents need not be cleared, because each entry is written before it is read.
- There is no back-pressure. A pixel is accepted on every edge with in_valid=1, and in_valid=0 cycles (gaps) freeze all state.
- Counters: col counts 0..IMG_WIDTH-1 and, on wrap, row counts 0..IMG_HEIGHT-1. When both wrap, the next accepted pixel starts a new frame with no idle cycle needed.
- Even col: latch in_data into the pair register.
- Odd col: hmax = signed max(pair register, in_data).
  - Even row: write hmax into line_buf[col>>1]. The line buffer is IMG_WIDTH/2 entries of DATA_WIDTH.
  - Odd row: register out_data = signed max(line_buf[col>>1], hmax) and assert out_valid on the next cycle.
- Latency: out_valid rises exactly 1 cycle after the edge accepting the bottom-right pixel of a window.
- Equal values: max returns the shared value, so ties need no special handling.
- frame_done asserts together with out_valid for window (row=IMG_HEIGHT-1, col=IMG_WIDTH-1).
- out_valid and frame_done deassert on the following cycle unless a new window completes.
- clr=1: col, row, pair register, out_valid and frame_done all go to 0 on that edge. A concurrent in_valid pixel is dropped (clr wins). out_data holds its value.
- A reset or clr in mid-frame discards the partial frame, and the next accepted pixel is treated as (0,0).
- Elaboration: an $error is raised if IMG_WIDTH or IMG_HEIGHT is odd or less than 2.

Optional Feature:
- Macro: POOL_AVG_EN.
- Defined:
  - Adds input port pool_mode (1 bit; 0 = max, 1 = average).
  - Average path accumulates the signed sum of the 4 window pixels at DATA_WIDTH+2 bits, stored in the line buffer and pair register at widened width.
  - out_data = sum >>> 2 (arithmetic shift, truncation toward negative infinity).
  - pool_mode is sampled only at the first pixel of each frame; changes mid-frame are ignored until the next frame.
  - Latency is identical to max mode.
- Undefined: the port does not exist, the block is max-only, and storage is DATA_WIDTH wide.

Decomposition:
- Package cnn_pool_pkg:
  - pool_mode_e enum (POOL_MAX=1'b0, POOL_AVG=1'b1).
  - signed pixel typedef pixel_t sized by a package-level DATA_WIDTH localparam.
  - smax() function.
- Sub-module pool_line_buffer:
  - Single-port register array of IMG_WIDTH/2 entries.
  - Write-enable and address inputs; combinational read.
  - Reused by future 3x3 pooling stages.

Test Plan:
- 4x4 frame, in_valid held high, pixels 0..15 → out_data 5,7,13,15. out_valid asserts 1 cycle after pixels 5,7,13,15 are accepted, and frame_done coincides with 15.
- Signed 2x2 window {-3,-8,-1,-128} → out_data = -1 (0xFF), not 0x80.
- Same 4x4 ramp with in_valid low on every other cycle → same outputs, each 1 cycle after its completing pixel. Nothing is emitted during gaps.
- Assert rst after 6 pixels, release, then send a full 0..15 frame → outputs 5,7,13,15 only. No stale window output.
- clr together with in_valid on pixel 9, then 16 new pixels of value 0x10 → pixel 9 dropped, outputs are four 0x10 values, and frame_done is on the fourth.
- POOL_AVG_EN defined, pool_mode=1, window {1,2,5,6} → out_data = 3. Window {-1,-1,-1,-2} → out_data = -2.
